// File: rtl/call_stack_unit_if.sv
// Stack command/response bundle: push/pop requests in, popped value, top view and status out.
// The master drives the requests and the slave (the stack) drives the results.
interface call_stack_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              clr_err;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [DATA_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_data, clr_err,
    input  pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, clr_err,
    output pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/call_stack_unit.sv
// LIFO stack with sticky overflow/underflow flags; one-cycle latency, a push or pop every cycle.
// No backpressure: illegal pushes/pops are dropped and flagged, and a push+pop pair is always accepted.
module call_stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  call_stack_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full_w;
  logic              empty_w;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [DATA_W-1:0] top_val;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  // With DEPTH a power of two the low bits of count wrap to 0 when full, so minus one still lands on the top slot.
  assign wr_idx  = count_q[IDX_W-1:0];
  assign top_idx = count_q[IDX_W-1:0] - IDX_W'(1);
  assign top_val = mem_q[top_idx];

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;

    if (bus.push && bus.pop) begin
      pop_valid_d = 1'b1;
      if (empty_w) begin
        pop_data_d = bus.push_data;
      end else begin
        pop_data_d     = top_val;
        mem_d[top_idx] = bus.push_data;
      end
    end else if (bus.push) begin
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        mem_d[wr_idx] = bus.push_data;
        count_d       = count_q + CNT_W'(1);
      end
    end else if (bus.pop) begin
      if (empty_w) begin
        underflow_d = 1'b1;
      end else begin
        pop_data_d  = top_val;
        pop_valid_d = 1'b1;
        count_d     = count_q - CNT_W'(1);
      end
    end

    if (reset) begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; entries at or above count are never read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.top_data  = empty_w ? '0 : top_val;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_call_stack_unit.sv
// Scoreboarded bench for call_stack_unit at DATA_W=16, DEPTH=4: directed cases then random traffic.
module tb_call_stack_unit;
  localparam int DW = 16;
  localparam int DP = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  call_stack_unit_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
  call_stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_mem [DP];
  int            m_cnt;
  logic [DW-1:0] m_pd;
  logic          m_pv;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference stack, then check every output after the edge.
  task automatic step(input logic ps, input logic pp, input logic [DW-1:0] d,
                      input logic clr, input logic rst);
    logic [DW-1:0] exp_top;
    bus.push      = ps;
    bus.pop       = pp;
    bus.push_data = d;
    bus.clr_err   = clr;
    reset         = rst;

    if (rst) begin
      m_cnt = 0; m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      exp_q.delete();
    end else begin
      m_pv  = 1'b0;
      m_ovf = m_ovf & ~clr;
      m_unf = m_unf & ~clr;
      if (ps && pp) begin
        m_pv = 1'b1;
        if (m_cnt == 0) m_pd = d;
        else begin
          m_pd = m_mem[m_cnt-1];
          m_mem[m_cnt-1] = d;
        end
        exp_q.push_back(m_pd);
      end else if (ps) begin
        if (m_cnt == DP) m_ovf = 1'b1;
        else begin
          m_mem[m_cnt] = d;
          m_cnt++;
        end
      end else if (pp) begin
        if (m_cnt == 0) m_unf = 1'b1;
        else begin
          m_pd = m_mem[m_cnt-1];
          m_cnt--;
          m_pv = 1'b1;
          exp_q.push_back(m_pd);
        end
      end
    end

    @(posedge clock);
    #1;
    exp_top = (m_cnt == 0) ? '0 : m_mem[m_cnt-1];
    chk("pop_valid", 32'(bus.pop_valid), 32'(m_pv));
    if (bus.pop_valid) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("sb_pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
    end
    chk("pop_data_hold", 32'(bus.pop_data), 32'(m_pd));
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("top_data", 32'(bus.top_data), 32'(exp_top));
    chk("full", 32'(bus.full), 32'(m_cnt == DP));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    @(negedge clock);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.clr_err = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_pop_data", 32'(bus.pop_data), 32'd0);

    // Fill to full.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_top", 32'(bus.top_data), 32'h4);
    chk("fill_ovf", 32'(bus.overflow), 32'd0);

    // Push while full is dropped and flagged; clr_err clears it.
    step(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_top", 32'(bus.top_data), 32'h4);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Drain in LIFO order.
    for (int i = 4; i >= 1; i--) begin
      step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      chk("drain_pd", 32'(bus.pop_data), 32'(i));
      chk("drain_pv", 32'(bus.pop_valid), 32'd1);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_top", 32'(bus.top_data), 32'd0);

    // Underflow, then set beats clear in the same cycle.
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("unf_set", 32'(bus.underflow), 32'd1);
    chk("unf_pv", 32'(bus.pop_valid), 32'd0);
    chk("unf_pd", 32'(bus.pop_data), 32'h1);
    step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    chk("unf_set_wins", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf_clr", 32'(bus.underflow), 32'd0);

    // Simultaneous push+pop: replace-top and empty bypass.
    step(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
    chk("pp_pd", 32'(bus.pop_data), 32'h2);
    chk("pp_top", 32'(bus.top_data), 32'h55);
    chk("pp_count", 32'(bus.count), 32'd2);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
    chk("byp_pd", 32'(bus.pop_data), 32'h77);
    chk("byp_count", 32'(bus.count), 32'd0);
    chk("byp_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Push+pop while full never flags overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0099, 1'b0, 1'b0);
    chk("fpp_pd", 32'(bus.pop_data), 32'h13);
    chk("fpp_ovf", 32'(bus.overflow), 32'd0);
    chk("fpp_count", 32'(bus.count), 32'd4);

    // Reset with push in the same cycle.
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h20 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h00EE, 1'b0, 1'b1);
    chk("rp_count", 32'(bus.count), 32'd0);
    chk("rp_empty", 32'(bus.empty), 32'd1);
    chk("rp_pv", 32'(bus.pop_valid), 32'd0);
    chk("rp_top", 32'(bus.top_data), 32'd0);
    chk("rp_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Random traffic against the reference stack.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
